// File: rtl/huffman_code_gen_pkg.sv
// Shared constants and FSM state type for the Huffman code generator.
package huffman_code_gen_pkg;

  localparam int N_SYM             = 6;
  localparam int N_MERGE           = 5;
  localparam int ROOT_MERGE        = 4;
  localparam int FIRST_INTERNAL_ID = 6;
  localparam int N_NODE            = N_SYM + N_MERGE - 1;
  localparam int LEN_W             = 3;
  localparam int K_W               = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/huffman_node_table.sv
// Per-node code/length register file with two write ports, one read port
// and a valid bit per entry used to detect a node being coded twice.
module huffman_node_table
  import huffman_code_gen_pkg::*;
#(
  parameter int CODE_W = 8,
  parameter int NODE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              we0,
  input  logic [NODE_W-1:0] waddr0,
  input  logic [CODE_W-1:0] wcode0,
  input  logic [LEN_W-1:0]  wlen0,
  input  logic              we1,
  input  logic [NODE_W-1:0] waddr1,
  input  logic [CODE_W-1:0] wcode1,
  input  logic [LEN_W-1:0]  wlen1,
  input  logic [NODE_W-1:0] raddr,
  output logic [CODE_W-1:0] rcode,
  output logic [LEN_W-1:0]  rlen,
  output logic [N_NODE-1:0] node_valid,
  output logic [CODE_W-1:0] sym_code [N_SYM],
  output logic [LEN_W-1:0]  sym_len  [N_SYM]
);

  logic [CODE_W-1:0] code_reg [N_NODE];
  logic [LEN_W-1:0]  len_reg  [N_NODE];

  genvar gi;
  generate
    for (gi = 0; gi < N_NODE; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          code_reg[gi]   <= '0;
          len_reg[gi]    <= '0;
          node_valid[gi] <= 1'b0;
        end else if (clear) begin
          code_reg[gi]   <= '0;
          len_reg[gi]    <= '0;
          node_valid[gi] <= 1'b0;
        end else if (we0 && waddr0 == NODE_W'(gi)) begin
          code_reg[gi]   <= wcode0;
          len_reg[gi]    <= wlen0;
          node_valid[gi] <= 1'b1;
        end else if (we1 && waddr1 == NODE_W'(gi)) begin
          code_reg[gi]   <= wcode1;
          len_reg[gi]    <= wlen1;
          node_valid[gi] <= 1'b1;
        end
      end
    end

    for (gi = 0; gi < N_SYM; gi++) begin : g_sym
      assign sym_code[gi] = code_reg[gi];
      assign sym_len[gi]  = len_reg[gi];
    end
  endgenerate

  // The root merge addresses one past the table; that read returns an empty node.
  always_comb begin
    rcode = '0;
    rlen  = '0;
    if (raddr < NODE_W'(N_NODE)) begin
      rcode = code_reg[raddr];
      rlen  = len_reg[raddr];
    end
  end

endmodule

// File: rtl/huffman_code_gen.sv
// Walks the five recorded merges root-first, one per cycle, and emits the
// per-symbol Huffman codes and masks with legality checking of the tree.
module huffman_code_gen
  import huffman_code_gen_pkg::*;
#(
  parameter int CODE_W = 8,
  parameter int NODE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tree_done,
  input  logic [NODE_W-1:0] tree_0_0,
  input  logic [NODE_W-1:0] tree_0_1,
  input  logic [NODE_W-1:0] tree_0_2,
  input  logic [NODE_W-1:0] tree_0_3,
  input  logic [NODE_W-1:0] tree_0_4,
  input  logic [NODE_W-1:0] tree_1_0,
  input  logic [NODE_W-1:0] tree_1_1,
  input  logic [NODE_W-1:0] tree_1_2,
  input  logic [NODE_W-1:0] tree_1_3,
  input  logic [NODE_W-1:0] tree_1_4,
  output logic [CODE_W-1:0] HC1,
  output logic [CODE_W-1:0] HC2,
  output logic [CODE_W-1:0] HC3,
  output logic [CODE_W-1:0] HC4,
  output logic [CODE_W-1:0] HC5,
  output logic [CODE_W-1:0] HC6,
  output logic [CODE_W-1:0] M1,
  output logic [CODE_W-1:0] M2,
  output logic [CODE_W-1:0] M3,
  output logic [CODE_W-1:0] M4,
  output logic [CODE_W-1:0] M5,
  output logic [CODE_W-1:0] M6,
  output logic              code_valid,
  output logic              code_err
);

  state_t            state;
  logic [K_W-1:0]    k;
  logic              tree_done_d;
  logic              start;
  logic [CODE_W-1:0] hc_reg [N_SYM];
  logic [CODE_W-1:0] m_reg  [N_SYM];

  logic [NODE_W-1:0] child0, child1, raddr;
  logic [CODE_W-1:0] rcode, pcode;
  logic [LEN_W-1:0]  rlen, plen, clen;
  logic [N_NODE-1:0] node_valid;
  logic [CODE_W-1:0] sym_code [N_SYM];
  logic [LEN_W-1:0]  sym_len  [N_SYM];
  logic              legal0, legal1, walk_go, clear;

  assign start   = tree_done & ~tree_done_d;
  assign walk_go = (state == WALK) && tree_done;
  assign clear   = (state == IDLE) && start;
  assign raddr   = NODE_W'(FIRST_INTERNAL_ID) + NODE_W'(k);

  always_comb begin
    child0 = tree_0_0;
    child1 = tree_1_0;
    case (k)
      3'd1:    begin child0 = tree_0_1; child1 = tree_1_1; end
      3'd2:    begin child0 = tree_0_2; child1 = tree_1_2; end
      3'd3:    begin child0 = tree_0_3; child1 = tree_1_3; end
      3'd4:    begin child0 = tree_0_4; child1 = tree_1_4; end
      default: begin child0 = tree_0_0; child1 = tree_1_0; end
    endcase
  end

  always_comb begin
    pcode = '0;
    plen  = '0;
    if (k != K_W'(ROOT_MERGE)) begin
      pcode = rcode;
      plen  = rlen;
    end
    clen = plen + LEN_W'(1);
  end

  // A child must exist, must already have been created by an earlier merge,
  // and must not be coded twice (including both children naming one node).
  always_comb begin
    legal0 = 1'b0;
    legal1 = 1'b0;
    if (child0 < NODE_W'(N_NODE))
      legal0 = !(child0 >= NODE_W'(FIRST_INTERNAL_ID) + NODE_W'(k)) && !node_valid[child0];
    if (child1 < NODE_W'(N_NODE))
      legal1 = !(child1 >= NODE_W'(FIRST_INTERNAL_ID) + NODE_W'(k)) && !node_valid[child1]
               && (child1 != child0);
  end

  huffman_node_table #(
    .CODE_W(CODE_W),
    .NODE_W(NODE_W)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .we0       (walk_go && legal0),
    .waddr0    (child0),
    .wcode0    ({pcode[CODE_W-2:0], 1'b0}),
    .wlen0     (clen),
    .we1       (walk_go && legal1),
    .waddr1    (child1),
    .wcode1    ({pcode[CODE_W-2:0], 1'b1}),
    .wlen1     (clen),
    .raddr     (raddr),
    .rcode     (rcode),
    .rlen      (rlen),
    .node_valid(node_valid),
    .sym_code  (sym_code),
    .sym_len   (sym_len)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      k           <= '0;
      tree_done_d <= 1'b0;
      code_valid  <= 1'b0;
      code_err    <= 1'b0;
      for (int i = 0; i < N_SYM; i++) begin
        hc_reg[i] <= '0;
        m_reg[i]  <= '0;
      end
    end else begin
      tree_done_d <= tree_done;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= WALK;
            k          <= K_W'(ROOT_MERGE);
            code_err   <= 1'b0;
            code_valid <= 1'b0;
            for (int i = 0; i < N_SYM; i++) begin
              hc_reg[i] <= '0;
              m_reg[i]  <= '0;
            end
          end
        end
        WALK: begin
          if (!tree_done) begin
            state <= IDLE;
          end else begin
            if (!legal0 || !legal1)
              code_err <= 1'b1;
            if (k == '0)
              state <= DONE;
            else
              k <= k - K_W'(1);
          end
        end
        DONE: begin
          for (int i = 0; i < N_SYM; i++) begin
            if (node_valid[i]) begin
              hc_reg[i] <= sym_code[i];
              m_reg[i]  <= ~({CODE_W{1'b1}} << sym_len[i]);
            end else begin
              hc_reg[i] <= '0;
              m_reg[i]  <= '0;
            end
          end
          if (!(&node_valid[N_SYM-1:0]))
            code_err <= 1'b1;
          state <= HOLD;
        end
        HOLD: begin
          if (!tree_done) begin
            state      <= IDLE;
            code_valid <= 1'b0;
          end else begin
            code_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign HC1 = hc_reg[0];
  assign HC2 = hc_reg[1];
  assign HC3 = hc_reg[2];
  assign HC4 = hc_reg[3];
  assign HC5 = hc_reg[4];
  assign HC6 = hc_reg[5];
  assign M1  = m_reg[0];
  assign M2  = m_reg[1];
  assign M3  = m_reg[2];
  assign M4  = m_reg[3];
  assign M5  = m_reg[4];
  assign M6  = m_reg[5];

endmodule

// File: tb/tb_huffman_code_gen.sv
// Directed self-checking bench for huffman_code_gen.
module tb_huffman_code_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tree_done = 1'b0;
  logic [3:0] t0 [5];
  logic [3:0] t1 [5];
  logic [7:0] hc1, hc2, hc3, hc4, hc5, hc6, m1, m2, m3, m4, m5, m6;
  logic       code_valid, code_err;
  logic [47:0] hc_obs, m_obs;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign hc_obs = {hc6, hc5, hc4, hc3, hc2, hc1};
  assign m_obs  = {m6, m5, m4, m3, m2, m1};

  huffman_code_gen #(.CODE_W(8), .NODE_W(4)) dut (
    .clk(clk), .reset(rst_n), .tree_done(tree_done),
    .tree_0_0(t0[0]), .tree_0_1(t0[1]), .tree_0_2(t0[2]), .tree_0_3(t0[3]), .tree_0_4(t0[4]),
    .tree_1_0(t1[0]), .tree_1_1(t1[1]), .tree_1_2(t1[2]), .tree_1_3(t1[3]), .tree_1_4(t1[4]),
    .HC1(hc1), .HC2(hc2), .HC3(hc3), .HC4(hc4), .HC5(hc5), .HC6(hc6),
    .M1(m1), .M2(m2), .M3(m3), .M4(m4), .M5(m5), .M6(m6),
    .code_valid(code_valid), .code_err(code_err)
  );

  // Packed as {k4,k3,k2,k1,k0}, one nibble per merge.
  task automatic set_tree(input logic [19:0] z, input logic [19:0] o);
    for (int i = 0; i < 5; i++) begin
      t0[i] = z[i*4 +: 4];
      t1[i] = o[i*4 +: 4];
    end
  endtask

  // Raise tree_done and wait (bounded) for code_valid; returns cycles waited or -1.
  task automatic run_frame(output int cyc);
    cyc = -1;
    @(negedge clk);
    tree_done = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (code_valid === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    tree_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({code_valid, code_err} !== 2'b00 || hc_obs !== 48'h0 || m_obs !== 48'h0) begin
      errors++;
      $display("FAIL reset: valid=%b err=%b hc=%h m=%h required 0", code_valid, code_err, hc_obs, m_obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (code_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: valid=%b required 0", code_valid);
    end
    $display("reset: done");
  endtask

  task automatic test_frame(input string name, input logic [19:0] z, input logic [19:0] o,
                            input logic [47:0] exp_hc, input logic [47:0] exp_m, input logic exp_err);
    int cyc;
    set_tree(z, o);
    run_frame(cyc);
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL %s_timeout: code_valid never rose within 20 cycles", name);
    end
    checks++;
    if (hc_obs !== exp_hc || m_obs !== exp_m || code_err !== exp_err) begin
      errors++;
      $display("FAIL %s: hc=%h m=%h err=%b required hc=%h m=%h err=%b",
               name, hc_obs, m_obs, code_err, exp_hc, exp_m, exp_err);
    end
    end_frame();
    checks++;
    if (code_valid !== 1'b0 || hc_obs !== exp_hc) begin
      errors++;
      $display("FAIL %s_release: valid=%b hc=%h required valid=0 hc=%h", name, code_valid, hc_obs, exp_hc);
    end
    $display("%s: hc=%h m=%h err=%b", name, hc_obs, m_obs, code_err);
  endtask

  task automatic test_latency();
    logic bad;
    set_tree(20'h01234, 20'h98765);
    @(negedge clk);
    tree_done = 1'b1;
    repeat (7) @(negedge clk);
    checks++;
    if (code_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: valid=%b after edge t+6 required 0", code_valid);
    end
    @(negedge clk);
    checks++;
    if (code_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_t7: valid=%b after edge t+7 required 1", code_valid);
    end
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (code_valid !== 1'b1 || hc_obs !== 48'h1F1E0E060200) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL latency_hold: valid=%b hc=%h required steady 1 and 1f1e0e060200", code_valid, hc_obs);
    end
    end_frame();
    $display("latency: done");
  endtask

  task automatic test_illegal_fwd();
    int cyc;
    set_tree(20'h01234, 20'h98785);
    run_frame(cyc);
    checks++;
    if (cyc < 0 || code_err !== 1'b1 || hc_obs[31:0] !== 32'h0E060200) begin
      errors++;
      $display("FAIL illegal_fwd: cyc=%0d err=%b hc=%h required valid err=1 hc[3:0]=0e060200",
               cyc, code_err, hc_obs);
    end
    end_frame();
    $display("illegal_fwd: err=%b hc=%h", code_err, hc_obs);
  endtask

  task automatic test_abort();
    logic bad;
    set_tree(20'h01234, 20'h98765);
    @(negedge clk);
    tree_done = 1'b1;
    repeat (3) @(negedge clk);
    tree_done = 1'b0;
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (code_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || hc_obs !== 48'h0 || m_obs !== 48'h0) begin
      errors++;
      $display("FAIL abort: valid_seen=%b hc=%h m=%h required 0", bad, hc_obs, m_obs);
    end
    $display("abort: hc=%h", hc_obs);
  endtask

  task automatic test_reset_async();
    int cyc;
    logic bad;
    set_tree(20'h01C34, 20'h98765);
    run_frame(cyc);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cyc < 0 || {code_valid, code_err} !== 2'b00 || hc_obs !== 48'h0 || m_obs !== 48'h0) begin
      errors++;
      $display("FAIL reset_hold: cyc=%0d valid=%b err=%b hc=%h m=%h required all 0",
               cyc, code_valid, code_err, hc_obs, m_obs);
    end
    tree_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tree_done = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    tree_done = 1'b0;
    #1;
    checks++;
    if ({code_valid, code_err} !== 2'b00 || hc_obs !== 48'h0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b err=%b hc=%h required 0", code_valid, code_err, hc_obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (code_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_restart: code_valid rose without a new tree_done edge");
    end
    $display("reset_async: done");
  endtask

  initial begin
    set_tree(20'h0, 20'h0);
    test_reset();
    test_frame("chain", 20'h01234, 20'h98765, 48'h1F1E0E060200, 48'h1F1F0F070301, 1'b0);
    test_frame("balanced", 20'h86420, 20'h97531, 48'h010007060504, 48'h030307070707, 1'b0);
    test_latency();
    test_frame("illegal_range", 20'h01C34, 20'h98765, 48'h1F1E0E000200, 48'h1F1F0F000301, 1'b1);
    test_illegal_fwd();
    test_abort();
    test_reset_async();
    test_frame("rerun_chain", 20'h01234, 20'h98765, 48'h1F1E0E060200, 48'h1F1F0F070301, 1'b0);
    test_frame("back_to_back", 20'h86420, 20'h97531, 48'h010007060504, 48'h030307070707, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
